// File: rtl/decode_queue.sv
// ---------------------------------------------------------------------------
// decode_queue
//   Instruction buffer plus decoder between fetch and the ID pipeline
//   register. Each accepted instruction is decoded to a 12-bit control vector
//   when it is enqueued. The vector is stored with the instruction word, its
//   PC and a branch-delay-slot tag in a DEPTH-entry circular FIFO.
//
// Parameters
//   DEPTH  FIFO entries; power of 2, >= 2
//   LS_EN  1: decode loads/stores; 0: load/store opcodes decode as reserved
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   flush      in   1   discard all entries and delay-slot tracking
//   in_valid   in   1   fetch presents an instruction
//   in_ready   out  1   queue can accept (count < DEPTH)
//   in_inst    in   32  instruction word
//   in_pc      in   32  instruction PC
//   out_valid  out  1   head entry valid (count != 0)
//   out_ready  in   1   ID consumes head
//   out_inst   out  32  head instruction (0 when out_valid=0)
//   out_pc     out  32  head PC (0 when out_valid=0)
//   out_ctrl   out  12  {ri,branch,jump,jal,jr,bal,aluSrc,memRead,memWrite,
//                        memToReg,regWrite,regDst} (0 when out_valid=0)
//   out_bd     out  1   head is in a branch delay slot (0 when out_valid=0)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high and flush is low. in_ready depends only on the occupancy count,
// so it never combinationally depends on out_ready; a full queue therefore
// refuses a write even in a cycle where the head is being consumed.
// ---------------------------------------------------------------------------
module decode_queue #(
    parameter int DEPTH = 4,
    parameter bit LS_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [11:0] out_ctrl,
    output logic        out_bd
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Control vector encodings
    localparam logic [11:0] CTRL_RI     = 12'h800;
    localparam logic [11:0] CTRL_RTYPE  = 12'h003;
    localparam logic [11:0] CTRL_NONE   = 12'h000;
    localparam logic [11:0] CTRL_JR     = 12'h280;
    localparam logic [11:0] CTRL_JALR   = 12'h083;
    localparam logic [11:0] CTRL_ALUIMM = 12'h022;
    localparam logic [11:0] CTRL_J      = 12'h200;
    localparam logic [11:0] CTRL_JAL    = 12'h102;
    localparam logic [11:0] CTRL_BR     = 12'h400;
    localparam logic [11:0] CTRL_BRAL   = 12'h442;
    localparam logic [11:0] CTRL_LOAD   = 12'h036;
    localparam logic [11:0] CTRL_STORE  = 12'h028;

    // State
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          bd_pend_q, bd_pend_d;

    logic [31:0] mem_inst_q [DEPTH];
    logic [31:0] mem_inst_d [DEPTH];
    logic [31:0] mem_pc_q   [DEPTH];
    logic [31:0] mem_pc_d   [DEPTH];
    logic [11:0] mem_ctrl_q [DEPTH];
    logic [11:0] mem_ctrl_d [DEPTH];
    logic        mem_bd_q   [DEPTH];
    logic        mem_bd_d   [DEPTH];

    logic        enq;
    logic        deq;
    logic [11:0] dec_ctrl;
    logic        dec_cti;

    // -----------------------------------------------------------------------
    // Decoder: purely combinational on in_inst
    // -----------------------------------------------------------------------
    always_comb begin
        dec_ctrl = CTRL_RI;
        unique case (in_inst[31:26])
            6'h00: begin
                unique case (in_inst[5:0])
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h10, 6'h12,
                    6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: dec_ctrl = CTRL_RTYPE;
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                    6'h0C, 6'h0D:                              dec_ctrl = CTRL_NONE;
                    6'h08:                                     dec_ctrl = CTRL_JR;
                    6'h09:                                     dec_ctrl = CTRL_JALR;
                    default:                                   dec_ctrl = CTRL_RI;
                endcase
            end
            6'h01: begin
                unique case (in_inst[20:16])
                    5'h00, 5'h01: dec_ctrl = CTRL_BR;
                    5'h10, 5'h11: dec_ctrl = CTRL_BRAL;
                    default:      dec_ctrl = CTRL_RI;
                endcase
            end
            6'h02:                             dec_ctrl = CTRL_J;
            6'h03:                             dec_ctrl = CTRL_JAL;
            6'h04, 6'h05, 6'h06, 6'h07:        dec_ctrl = CTRL_BR;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F:        dec_ctrl = CTRL_ALUIMM;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: dec_ctrl = LS_EN ? CTRL_LOAD : CTRL_RI;
            6'h28, 6'h29, 6'h2B:               dec_ctrl = LS_EN ? CTRL_STORE : CTRL_RI;
            default:                           dec_ctrl = CTRL_RI;
        endcase
    end

    // Branch/jump class (branch|jump|jal|jr|bal). Reserved encodings have all
    // of these clear, so they never open a delay slot.
    assign dec_cti = |dec_ctrl[10:6];

    // -----------------------------------------------------------------------
    // Handshakes and status
    // -----------------------------------------------------------------------
    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign enq       = in_valid & in_ready & ~flush;
    assign deq       = out_valid & out_ready & ~flush;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        bd_pend_d  = bd_pend_q;
        mem_inst_d = mem_inst_q;
        mem_pc_d   = mem_pc_q;
        mem_ctrl_d = mem_ctrl_q;
        mem_bd_d   = mem_bd_q;

        if (flush) begin
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            bd_pend_d = 1'b0;
        end else begin
            if (enq) begin
                mem_inst_d[wr_ptr_q] = in_inst;
                mem_pc_d[wr_ptr_q]   = in_pc;
                mem_ctrl_d[wr_ptr_q] = dec_ctrl;
                // The slot tag comes from the previously accepted
                // instruction; this instruction then decides the next tag.
                mem_bd_d[wr_ptr_q]   = bd_pend_q;
                bd_pend_d            = dec_cti;
                wr_ptr_d             = wr_ptr_q + AW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            bd_pend_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            bd_pend_q <= bd_pend_d;
        end
    end

    // Entry storage needs no reset: it is only visible through out_* while
    // out_valid=1, and every visible entry was written by an enqueue.
    always_ff @(posedge clk) begin
        mem_inst_q <= mem_inst_d;
        mem_pc_q   <= mem_pc_d;
        mem_ctrl_q <= mem_ctrl_d;
        mem_bd_q   <= mem_bd_d;
    end

    // -----------------------------------------------------------------------
    // Head outputs, zeroed while empty
    // -----------------------------------------------------------------------
    assign out_inst = out_valid ? mem_inst_q[rd_ptr_q] : 32'h0;
    assign out_pc   = out_valid ? mem_pc_q[rd_ptr_q]   : 32'h0;
    assign out_ctrl = out_valid ? mem_ctrl_q[rd_ptr_q] : 12'h0;
    assign out_bd   = out_valid ? mem_bd_q[rd_ptr_q]   : 1'b0;

endmodule

// File: tb/tb_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_decode_queue
//   Two instances share one stimulus stream: dut_a decodes loads/stores,
//   dut_b treats them as reserved. A queue-based model predicts every output
//   of both instances each cycle; directed steps add literal expectations.
// ---------------------------------------------------------------------------
module tb_decode_queue;

    localparam int DEPTH = 4;

    // -----------------------------------------------------------------------
    // Clock / reset / stimulus signals
    // -----------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = 32'h0;
    logic [31:0] in_pc = 32'h0;

    always #5 clk = ~clk;

    logic        a_in_ready, a_out_valid, a_out_bd;
    logic [31:0] a_out_inst, a_out_pc;
    logic [11:0] a_out_ctrl;
    logic        b_in_ready, b_out_valid, b_out_bd;
    logic [31:0] b_out_inst, b_out_pc;
    logic [11:0] b_out_ctrl;

    decode_queue #(.DEPTH(DEPTH), .LS_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_inst(a_out_inst), .out_pc(a_out_pc),
        .out_ctrl(a_out_ctrl), .out_bd(a_out_bd)
    );

    decode_queue #(.DEPTH(DEPTH), .LS_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_inst(b_out_inst), .out_pc(b_out_pc),
        .out_ctrl(b_out_ctrl), .out_bd(b_out_bd)
    );

    // -----------------------------------------------------------------------
    // Check bookkeeping
    // -----------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference decode, written straight from the opcode table
    // -----------------------------------------------------------------------
    function automatic logic [11:0] model_ctrl(input logic [31:0] inst, input bit ls_en);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        op = inst[31:26];
        fn = inst[5:0];
        rt = inst[20:16];
        if (op == 6'h00) begin
            if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                           [6'h20:6'h27], 6'h2A, 6'h2B}) return 12'h003;
            if (fn inside {6'h11, 6'h13, [6'h18:6'h1B], 6'h0C, 6'h0D}) return 12'h000;
            if (fn == 6'h08) return 12'h280;
            if (fn == 6'h09) return 12'h083;
            return 12'h800;
        end
        if (op == 6'h01) begin
            if (rt inside {5'h00, 5'h01}) return 12'h400;
            if (rt inside {5'h10, 5'h11}) return 12'h442;
            return 12'h800;
        end
        if (op == 6'h02) return 12'h200;
        if (op == 6'h03) return 12'h102;
        if (op inside {[6'h04:6'h07]}) return 12'h400;
        if (op inside {[6'h08:6'h0F]}) return 12'h022;
        if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return ls_en ? 12'h036 : 12'h800;
        if (op inside {6'h28, 6'h29, 6'h2B}) return ls_en ? 12'h028 : 12'h800;
        return 12'h800;
    endfunction

    function automatic bit model_is_cti(input logic [31:0] inst);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        op = inst[31:26];
        fn = inst[5:0];
        rt = inst[20:16];
        if (op == 6'h00) return (fn == 6'h08) || (fn == 6'h09);
        if (op == 6'h01) return rt inside {5'h00, 5'h01, 5'h10, 5'h11};
        return op inside {[6'h02:6'h07]};
    endfunction

    // -----------------------------------------------------------------------
    // Scoreboard: expected FIFO contents as {bd, pc, inst}
    // -----------------------------------------------------------------------
    logic [64:0] exp_q[$];
    bit          m_bd_pend = 1'b0;
    bit          model_live = 1'b0;

    always @(posedge clk) begin
        bit m_enq;
        bit m_deq;
        if (rst) begin
            exp_q.delete();
            m_bd_pend = 1'b0;
            model_live = 1'b1;
        end else if (flush) begin
            exp_q.delete();
            m_bd_pend = 1'b0;
        end else begin
            m_enq = in_valid && (exp_q.size() < DEPTH);
            m_deq = out_ready && (exp_q.size() != 0);
            if (m_deq) void'(exp_q.pop_front());
            if (m_enq) begin
                exp_q.push_back({m_bd_pend, in_pc, in_inst});
                m_bd_pend = model_is_cti(in_inst);
            end
        end
    end

    // Compare process: outputs depend only on registered state, so the
    // falling edge sees them settled regardless of input changes.
    always @(negedge clk) begin
        logic [64:0] head;
        bit          ev;
        if (model_live) begin
            ev   = (exp_q.size() != 0);
            head = ev ? exp_q[0] : 65'h0;
            chk("a_in_ready",  32'(a_in_ready),  32'(exp_q.size() < DEPTH));
            chk("a_out_valid", 32'(a_out_valid), 32'(ev));
            chk("a_out_inst",  a_out_inst,       head[31:0]);
            chk("a_out_pc",    a_out_pc,         head[63:32]);
            chk("a_out_ctrl",  32'(a_out_ctrl),  ev ? 32'(model_ctrl(head[31:0], 1'b1)) : 32'h0);
            chk("a_out_bd",    32'(a_out_bd),    32'(head[64]));
            chk("b_in_ready",  32'(b_in_ready),  32'(exp_q.size() < DEPTH));
            chk("b_out_valid", 32'(b_out_valid), 32'(ev));
            chk("b_out_inst",  b_out_inst,       head[31:0]);
            chk("b_out_pc",    b_out_pc,         head[63:32]);
            chk("b_out_ctrl",  32'(b_out_ctrl),  ev ? 32'(model_ctrl(head[31:0], 1'b0)) : 32'h0);
            chk("b_out_bd",    32'(b_out_bd),    32'(head[64]));
        end
    end

    // -----------------------------------------------------------------------
    // Driver: apply one cycle of inputs, return at the next falling edge
    // -----------------------------------------------------------------------
    task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rdy, input logic fl);
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
    endtask

    // Stream of mixed encodings, consumed as fast as it is produced.
    logic [31:0] stream [12] = '{
        32'h08000000,  // J          -> 200
        32'h00220018,  // MULT       -> 000, delay slot
        32'h0040F809,  // JALR       -> 083
        32'h80220000,  // LB         -> 036 / 800, delay slot
        32'h04100002,  // BLTZAL     -> 442
        32'hA0220000,  // SB         -> 028 / 800, delay slot
        32'h03E00008,  // JR         -> 280
        32'h04020000,  // REGIMM rt=2-> 800, delay slot
        32'h3C01BFC0,  // LUI        -> 022, not a delay slot
        32'h00000001,  // bad funct  -> 800
        32'h14000000,  // BNE        -> 400
        32'h0000000C   // SYSCALL    -> 000, delay slot
    };

    initial begin
        // 1. Reset for two cycles
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(a_out_valid), 32'h0);
        chk("rst_in_ready",  32'(a_in_ready),  32'h1);
        chk("rst_out_inst",  a_out_inst,       32'h0);
        chk("rst_out_pc",    a_out_pc,         32'h0);
        chk("rst_out_ctrl",  32'(a_out_ctrl),  32'h0);
        chk("rst_out_bd",    32'(a_out_bd),    32'h0);

        // 2. Single ADDU, visible the next cycle
        cyc(1'b1, 32'h00221821, 32'hBFC00000, 1'b0, 1'b0);
        chk("addu_valid", 32'(a_out_valid), 32'h1);
        chk("addu_ctrl",  32'(a_out_ctrl),  32'h003);
        chk("addu_pc",    a_out_pc,         32'hBFC00000);
        chk("addu_bd",    32'(a_out_bd),    32'h0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 3. BEQ then SW: SW sits in the delay slot
        cyc(1'b1, 32'h10220003, 32'h00000004, 1'b0, 1'b0);
        cyc(1'b1, 32'hAC220004, 32'h00000008, 1'b0, 1'b0);
        chk("beq_ctrl", 32'(a_out_ctrl), 32'h400);
        chk("beq_bd",   32'(a_out_bd),   32'h0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("sw_ctrl",  32'(a_out_ctrl), 32'h028);
        chk("sw_bd",    32'(a_out_bd),   32'h1);
        chk("sw_ctrl_nols", 32'(b_out_ctrl), 32'h800);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 4. Fill to DEPTH with the consumer stalled
        for (int k = 0; k < DEPTH; k++)
            cyc(1'b1, 32'h00000020 | (32'(k) << 11), 32'h100 + 32'(4 * k), 1'b0, 1'b0);
        chk("full_in_ready",  32'(a_in_ready),  32'h0);
        chk("full_out_valid", 32'(a_out_valid), 32'h1);
        chk("full_head_pc",   a_out_pc,         32'h100);
        // Full: the offered word is refused even though the head pops
        cyc(1'b1, 32'h00005820, 32'h200, 1'b1, 1'b0);
        chk("pop_in_ready", 32'(a_in_ready), 32'h1);
        chk("pop_head_pc",  a_out_pc,        32'h104);
        // Fetch holds the refused word; now enq and deq overlap
        cyc(1'b1, 32'h00005820, 32'h200, 1'b1, 1'b0);
        chk("overlap_head_pc", a_out_pc, 32'h108);
        for (int k = 1; k < 4; k++)
            cyc(1'b1, 32'h00005822, 32'h200 + 32'(4 * k), 1'b1, 1'b0);
        for (int k = 0; k < DEPTH + 1; k++)
            cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drained_valid", 32'(a_out_valid), 32'h0);

        // 5. Flush drops the concurrent JAL and clears the pending slot
        cyc(1'b1, 32'h10220003, 32'h300, 1'b0, 1'b0);
        cyc(1'b1, 32'h0C000010, 32'h304, 1'b0, 1'b1);
        chk("flush_valid",    32'(a_out_valid), 32'h0);
        chk("flush_in_ready", 32'(a_in_ready),  32'h1);
        cyc(1'b1, 32'h00221821, 32'h400, 1'b0, 1'b0);
        chk("post_flush_pc", a_out_pc,        32'h400);
        chk("post_flush_bd", 32'(a_out_bd),   32'h0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 6. Reserved opcode and LW under both LS_EN settings
        cyc(1'b1, 32'hFC000000, 32'h500, 1'b0, 1'b0);
        chk("ri_ctrl", 32'(a_out_ctrl), 32'h800);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h8C220000, 32'h504, 1'b0, 1'b0);
        chk("lw_ctrl_ls",   32'(a_out_ctrl), 32'h036);
        chk("lw_ctrl_nols", 32'(b_out_ctrl), 32'h800);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Mixed stream, one in / one out per cycle
        for (int k = 0; k < 12; k++)
            cyc(1'b1, stream[k], 32'h600 + 32'(4 * k), 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("end_valid", 32'(a_out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
